shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Parametrised sequential shift-and-add multiplier with its own datapath and bit counter: WIDTH-bit operands, 2*WIDTH-bit product.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Provides a start/idle/done handshake for the surrounding arithmetic datapath.
- Successor to the fixed 4-state add/shift controller: control, counter and sign correction are integrated in one block.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- st  input  1  start request, sampled only in IDLE
- sgn  input  1  1 = signed (two's complement) operation, 0 = unsigned; sampled with st
- a  input  WIDTH  multiplicand; sampled with st
- b  input  WIDTH  multiplier; sampled with st
- product  output  2*WIDTH  result register
- idle  output  1  high in IDLE
- busy  output  1  high in ADD, SHIFT and FIX
- load  output  1  one-cycle pulse, registered, in the cycle after st is accepted
- done  output  1  high for exactly one cycle in DONE; product valid from then on

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, mcand=0, count=0, neg=0, product=0, idle=1, busy=0, load=0, done=0.
- States: IDLE, ADD, SHIFT, FIX, DONE. Outputs idle, busy and done decode from state only.
- IDLE, st=1 at a rising edge:
  - mcand <= |a| if sgn, else a.
  - acc <= {(WIDTH+1)'b0, (|b| if sgn, else b)}.
  - neg <= sgn & (a[MSB] ^ b[MSB]); count <= 0; load <= 1; next state ADD.
- IDLE, st=0: state holds; product holds.
- Magnitudes: |-2^(WIDTH-1)| = 2^(WIDTH-1), which fits in WIDTH unsigned bits. No overflow case exists.
- acc is 2*WIDTH+1 bits: {carry, hi[WIDTH], lo[WIDTH]}.
- ADD: if acc[0]=1, {carry,hi} <= hi + mcand (WIDTH+1-bit result); otherwise acc holds. Next state SHIFT.
- SHIFT: acc <= acc >> 1, zero filled. count <= count+1.
  - If count == WIDTH-1 before the increment, next state FIX; otherwise ADD.
  - This gives exactly WIDTH ADD/SHIFT pairs.
- FIX: product <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0], negated modulo 2^(2*WIDTH). Next state DONE.
- DONE: done=1 for one cycle; next state IDLE unconditionally.
- st is ignored in DONE. A new operation requires st sampled in IDLE.
- Latency: st accepted at edge E0, done high in the cycle after edge E0 + 2*WIDTH + 1.
- Total: 2*WIDTH+2 cycles from st acceptance to the done cycle, including the done cycle. WIDTH=8 gives 18.
- st, a, b and sgn changes while not in IDLE have no effect.
- product changes only in FIX or on reset. It holds through IDLE until the next FIX.
- load is high only in the first ADD cycle.
- Reset mid-operation aborts immediately. No done pulse occurs; product=0.
- Zero operand: full latency is still used; product=0. A signed zero result is never -0, because negating 0 yields 0.

Test Plan:
- WIDTH=8, sgn=0, a=13, b=11, st pulse -> done exactly 18 cycles after acceptance, product=0x008F; load pulses once; busy high 17 cycles.
- WIDTH=8, sgn=0, a=255, b=255 -> product=0xFE01; then sgn=1, a=0xFD(-3), b=0x05 -> product=0xFFF1 (-15).
- WIDTH=8, sgn=1, a=0x80, b=0x80 -> product=0x4000; a=0x80, b=0x01 -> product=0xFF80.
- Hold st=1 continuously with operands changed mid-operation -> first result uses the values sampled at acceptance. Next operation starts only from IDLE, one cycle after done.
- Assert rst during cycle 5 of an operation -> same cycle: idle=1, busy=0, product=0; no done pulse. A fresh op 7*6 (unsigned) -> 0x002A.
- WIDTH=4 instance: sgn=0, 15*15 -> 0xE1 after 10 cycles; sgn=1, 0x8*0x7 -> 0xC8 (-56); a=0 -> product 0, full latency.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add multiplier, unsigned or signed per operation
// Multiplies operand magnitudes over WIDTH add/shift pairs, then applies the sign in a final FIX step.
module shift_add_multiplier #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 idle,
    output logic                 busy,
    output logic                 load,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic               neg;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] raw;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
    assign mag_a = (sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    assign raw   = acc[2*WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = st ? S_ADD : S_IDLE;
            S_ADD:   state_nxt = S_SHIFT;
            S_SHIFT: state_nxt = (count == LAST) ? S_FIX : S_ADD;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            count   <= '0;
            neg     <= 1'b0;
            product <= '0;
            load    <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (st) begin
                        mcand <= mag_a;
                        acc   <= {{(WIDTH+1){1'b0}}, mag_b};
                        neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count <= '0;
                        load  <= 1'b1;
                    end
                end
                S_ADD: begin
                    if (acc[0]) begin
                        acc[2*WIDTH:WIDTH] <= sum;
                    end
                end
                S_SHIFT: begin
                    acc   <= acc >> 1;
                    count <= count + CW'(1);
                end
                S_FIX: begin
                    // negating zero gives zero, so a signed zero result is never -0
                    product <= neg ? (~raw + (2*WIDTH)'(1)) : raw;
                end
                default: ;
            endcase
        end
    end

    assign idle = (state == S_IDLE);
    assign busy = (state == S_ADD) || (state == S_SHIFT) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule
